stamp_capture_counter: RTL and testbench

//   Free-running timestamp counter with NCH independent snapshot channels.

---
 rtl/stamp_capture_counter_if.sv | 34 +++
 rtl/stamp_capture_counter.sv | 113 +++++++++++
 tb/tb_stamp_capture_counter.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/stamp_capture_counter_if.sv
// ============================================================================
//  Module   : stamp_capture_counter_if
//  Brief    : Control/capture bundle for the shared-timebase stamp counter.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface stamp_capture_counter_if #(
    parameter int WIDTH = 16,
    parameter int NCH   = 4
);
    logic                  en;
    logic                  clear;
    logic [NCH-1:0]        cap;
    logic [NCH-1:0]        ack;
    logic [WIDTH-1:0]      cnt;
    logic [NCH*WIDTH-1:0]  val;
    logic [NCH-1:0]        valid;
    logic [NCH-1:0]        ovr;
    logic                  wrap;
    logic                  sat;

    modport master (
        output en, clear, cap, ack,
        input  cnt, val, valid, ovr, wrap, sat
    );

    modport slave (
        input  en, clear, cap, ack,
        output cnt, val, valid, ovr, wrap, sat
    );
endinterface

`default_nettype wire

// File: rtl/stamp_capture_counter.sv
// ============================================================================
//  Module   : stamp_capture_counter
//  Brief    : Free-running timestamp counter with NCH snapshot channels.
//             Optional macro STAMP_PRESCALE_EN enables an en-cycle divider.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module stamp_capture_counter #(
    parameter int WIDTH    = 16,
    parameter int NCH      = 4,
    parameter int SATURATE = 0,
    parameter int PRESCALE = 1
) (
    input  wire logic               clk,
    input  wire logic               reset,
    stamp_capture_counter_if.slave  bus
);

    localparam logic [WIDTH-1:0] c_max = {WIDTH{1'b1}};

    logic [WIDTH-1:0] r_cnt;
    logic             r_wrap;
    logic             r_sat;
    logic             w_tick;

`ifdef STAMP_PRESCALE_EN
    localparam int               c_dw       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [c_dw-1:0]  c_div_last = c_dw'(PRESCALE - 1);

    logic [c_dw-1:0] r_div;

    assign w_tick = bus.en && (r_div == c_div_last);

    always_ff @(posedge clk) begin
        if (reset || bus.clear) begin
            r_div <= '0;
        end else if (bus.en) begin
            r_div <= (r_div == c_div_last) ? '0 : r_div + c_dw'(1);
        end
    end
`else
    logic w_unused_prescale;
    assign w_unused_prescale = (PRESCALE != 0);
    assign w_tick            = bus.en;
`endif

    // wrap is a registered pulse, so it lines up with the cycle cnt reads 0
    always_ff @(posedge clk) begin
        if (reset || bus.clear) begin
            r_cnt  <= '0;
            r_wrap <= 1'b0;
            r_sat  <= 1'b0;
        end else begin
            r_wrap <= 1'b0;
            if (w_tick) begin
                if (r_cnt == c_max) begin
                    if (SATURATE != 0) begin
                        r_sat <= 1'b1;
                    end else begin
                        r_cnt  <= '0;
                        r_wrap <= 1'b1;
                    end
                end else begin
                    r_cnt <= r_cnt + WIDTH'(1);
                end
            end
        end
    end

    assign bus.cnt  = r_cnt;
    assign bus.wrap = r_wrap;
    assign bus.sat  = r_sat;

    generate
        for (genvar i = 0; i < NCH; i++) begin : g_ch
            logic [WIDTH-1:0] r_val;
            logic             r_valid;
            logic             r_ovr;
            logic             w_overrun;

            // simultaneous ack frees the slot, so a same-edge capture is not an overrun
            assign w_overrun = bus.cap[i] && r_valid && !bus.ack[i];

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_val   <= '0;
                    r_valid <= 1'b0;
                    r_ovr   <= 1'b0;
                end else begin
                    if (bus.cap[i]) begin
                        r_val   <= r_cnt;
                        r_valid <= 1'b1;
                    end else if (bus.ack[i]) begin
                        r_valid <= 1'b0;
                    end
                    if (bus.clear) begin
                        r_ovr <= w_overrun;
                    end else if (w_overrun) begin
                        r_ovr <= 1'b1;
                    end
                end
            end

            assign bus.val[i*WIDTH +: WIDTH] = r_val;
            assign bus.valid[i]              = r_valid;
            assign bus.ovr[i]                = r_ovr;
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_stamp_capture_counter.sv
// ============================================================================
//  Module   : tb_stamp_capture_counter
//  Brief    : Randomized bench: wrapping and saturating instances vs. a model.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_stamp_capture_counter;
    localparam int W = 4;
    localparam int N = 4;
    localparam int P = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic         en;
    logic         clear;
    logic [N-1:0] cap;
    logic [N-1:0] ack;

    stamp_capture_counter_if #(.WIDTH(W), .NCH(N)) bus_w ();
    stamp_capture_counter_if #(.WIDTH(W), .NCH(N)) bus_s ();

    assign bus_w.en = en;  assign bus_w.clear = clear;
    assign bus_w.cap = cap; assign bus_w.ack = ack;
    assign bus_s.en = en;  assign bus_s.clear = clear;
    assign bus_s.cap = cap; assign bus_s.ack = ack;

    stamp_capture_counter #(.WIDTH(W), .NCH(N), .SATURATE(0), .PRESCALE(P)) u_wrap (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_w)
    );

    stamp_capture_counter #(.WIDTH(W), .NCH(N), .SATURATE(1), .PRESCALE(P)) u_sat (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_s)
    );

    logic [W-1:0]   o_cnt   [2];
    logic [N*W-1:0] o_val   [2];
    logic [N-1:0]   o_valid [2];
    logic [N-1:0]   o_ovr   [2];
    logic           o_wrap  [2];
    logic           o_sat   [2];

    assign o_cnt[0] = bus_w.cnt;     assign o_cnt[1] = bus_s.cnt;
    assign o_val[0] = bus_w.val;     assign o_val[1] = bus_s.val;
    assign o_valid[0] = bus_w.valid; assign o_valid[1] = bus_s.valid;
    assign o_ovr[0] = bus_w.ovr;     assign o_ovr[1] = bus_s.ovr;
    assign o_wrap[0] = bus_w.wrap;   assign o_wrap[1] = bus_s.wrap;
    assign o_sat[0] = bus_s.sat === 1'bx ? 1'bx : bus_w.sat;
    assign o_sat[1] = bus_s.sat;

    int n_checks = 0;
    int n_errors = 0;

    // reference state: index 0 = wrapping instance, 1 = saturating instance
    int m_cnt [2];
    int m_div [2];
    int m_wrap[2];
    int m_sat [2];
    int m_val  [2][N];
    int m_valid[2][N];
    int m_ovr  [2][N];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        int maxv;
        int tick;
        int ov;
        maxv = (1 << W) - 1;
        for (int s = 0; s < 2; s++) begin
            if (reset) begin
                m_cnt[s] = 0; m_div[s] = 0; m_wrap[s] = 0; m_sat[s] = 0;
                for (int i = 0; i < N; i++) begin
                    m_val[s][i] = 0; m_valid[s][i] = 0; m_ovr[s][i] = 0;
                end
            end else begin
                for (int i = 0; i < N; i++) begin
                    ov = (cap[i] && m_valid[s][i] && !ack[i]) ? 1 : 0;
                    if (cap[i]) begin
                        m_val[s][i]   = m_cnt[s];
                        m_valid[s][i] = 1;
                    end else if (ack[i]) begin
                        m_valid[s][i] = 0;
                    end
                    m_ovr[s][i] = (clear ? 0 : m_ovr[s][i]) | ov;
                end
`ifdef STAMP_PRESCALE_EN
                tick = (en && m_div[s] == P - 1) ? 1 : 0;
                if (clear)   m_div[s] = 0;
                else if (en) m_div[s] = (m_div[s] + 1) % P;
`else
                tick = en ? 1 : 0;
`endif
                m_wrap[s] = 0;
                if (clear) begin
                    m_cnt[s] = 0;
                    m_sat[s] = 0;
                end else if (tick != 0) begin
                    if (m_cnt[s] < maxv)  m_cnt[s] = m_cnt[s] + 1;
                    else if (s == 1)      m_sat[s] = 1;
                    else begin
                        m_cnt[s]  = 0;
                        m_wrap[s] = 1;
                    end
                end
            end
        end
    endtask

    task automatic check_all();
        for (int s = 0; s < 2; s++) begin
            check($sformatf("cnt[%0d]", s),  32'(o_cnt[s]),  32'(m_cnt[s]));
            check($sformatf("wrap[%0d]", s), 32'(o_wrap[s]), 32'(m_wrap[s]));
            check($sformatf("sat[%0d]", s),  32'(o_sat[s]),  32'(m_sat[s]));
            for (int i = 0; i < N; i++) begin
                check($sformatf("val[%0d][%0d]", s, i),   32'(o_val[s][i*W +: W]), 32'(m_val[s][i]));
                check($sformatf("valid[%0d][%0d]", s, i), 32'(o_valid[s][i]),      32'(m_valid[s][i]));
                check($sformatf("ovr[%0d][%0d]", s, i),   32'(o_ovr[s][i]),        32'(m_ovr[s][i]));
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic idle();
        reset = 1'b0; clear = 1'b0; cap = '0; ack = '0;
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; clear = 1'b0; cap = '0; ack = '0;
        step();
        step();

        // count from zero, capture channel 0 mid-run
        idle(); en = 1'b1;
        for (int k = 0; k < 10; k++) begin
            cap = (k == 5) ? 4'b0001 : 4'b0000;
            step();
        end

        // run across the max boundary for both wrap and saturate
        idle(); en = 1'b1;
        for (int k = 0; k < 40; k++) step();
        en = 1'b0;
        step(); step();
        clear = 1'b1; step();
        idle(); en = 1'b1;

        // overrun on channel 1, then acknowledge
        cap = 4'b0010; step();
        idle(); step(); step();
        cap = 4'b0010; step();
        idle(); ack = 4'b0010; step();
        idle(); step();

        // capture+ack same edge on channel 2, then all channels together
        cap = 4'b0100; step();
        cap = 4'b0100; ack = 4'b0100; step();
        idle(); cap = 4'b1111; step();
        idle(); cap = 4'b1111; clear = 1'b1; step();
        idle(); step();

        // mid-run reset
        reset = 1'b1; step();
        idle(); step();

        for (int k = 0; k < 800; k++) begin
            reset = ($urandom_range(0, 99) == 0);
            clear = ($urandom_range(0, 29) == 0);
            en    = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) begin
                cap[i] = ($urandom_range(0, 4) == 0);
                ack[i] = ($urandom_range(0, 3) == 0);
            end
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

`default_nettype wire
